survivor_traceback_unit: RTL and testbench

SURVIVOR_TRACEBACK_UNIT -- requirements
Module: survivor_traceback_unit

---
 rtl/viterbi_pkg.sv | 19 +
 rtl/survivor_mem.sv | 29 ++
 rtl/survivor_traceback_unit.sv | 149 ++++++++++++++
 tb/tb_survivor_traceback_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared types for the K=3 Viterbi survivor traceback.
// NUM_STATES / STATE_BITS describe the 4-state trellis; dec_t carries one
// ACS decision bit per state; fsm_t is the traceback controller state.
package viterbi_pkg;

    localparam int unsigned NUM_STATES       = 4;
    localparam int unsigned STATE_BITS       = 2;
    localparam int unsigned TB_DEPTH_DEFAULT = 16;

    typedef logic [STATE_BITS-1:0] state_t;
    typedef logic [NUM_STATES-1:0] dec_t;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_TRACE = 2'd1,
        ST_EMIT  = 2'd2
    } fsm_t;

endpackage

// File: rtl/survivor_mem.sv
// Survivor decision memory: register array, one synchronous write port,
// one asynchronous read port.
// Ports: clk, wr_en/wr_addr/wr_data (write), rd_addr -> rd_data (async read).
module survivor_mem
    import viterbi_pkg::*;
#(
    parameter int unsigned DEPTH  = TB_DEPTH_DEFAULT,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  dec_t              wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output dec_t              rd_data
);

    dec_t mem [DEPTH];

    // Contents are rewritten every block, so no reset is needed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/survivor_traceback_unit.sv
// Block traceback for a 4-state (K=3) Viterbi decoder.
// Collects TB_DEPTH decision words (FILL), walks the trellis backwards one
// step per cycle (TRACE), then emits the decoded bits in forward order (EMIT).
// Ports:
//   i_clk, i_rst_n         clock, async active-low reset
//   i_valid, i_dec         decision word input (accepted when o_ready)
//   i_best_state           minimum-metric state sampled with the last word
//   o_ready                high only while filling
//   o_valid, o_bit, o_last decoded bit stream, o_last on final bit of block
// Build option: TRACEBACK_BEST_STATE_EN selects i_best_state as the traceback
// start state; otherwise the block starts from state 0 (zero-terminated).
module survivor_traceback_unit
    import viterbi_pkg::*;
#(
    parameter int unsigned TB_DEPTH   = TB_DEPTH_DEFAULT,
    parameter int unsigned SIZE_STATE = STATE_BITS
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    input  logic [3:0]            i_dec,
    input  logic [SIZE_STATE-1:0] i_best_state,
    output logic                  o_ready,
    output logic                  o_valid,
    output logic                  o_bit,
    output logic                  o_last
);

    localparam int unsigned CNT_W = $clog2(TB_DEPTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TB_DEPTH - 1);

    fsm_t               state, state_n;
    logic [CNT_W-1:0]   wr_ptr, wr_ptr_n;
    logic [CNT_W-1:0]   step, step_n;
    logic [CNT_W-1:0]   step_p1;
    state_t             cur_s, cur_s_n;
    state_t             start_s;
    logic [TB_DEPTH-1:0] out_buf, out_buf_n;
    logic               mem_we;
    dec_t               rd_dec;
    logic               ready_n, valid_n, bit_n, last_n;

`ifdef TRACEBACK_BEST_STATE_EN
    assign start_s = state_t'(i_best_state);
`else
    logic unused_best_state;
    assign unused_best_state = ^i_best_state;
    assign start_s = '0;
`endif

    survivor_mem #(
        .DEPTH  (TB_DEPTH),
        .ADDR_W (CNT_W)
    ) u_mem (
        .clk     (i_clk),
        .wr_en   (mem_we),
        .wr_addr (wr_ptr),
        .wr_data (dec_t'(i_dec)),
        .rd_addr (step),
        .rd_data (rd_dec)
    );

    assign step_p1 = step + CNT_W'(1);

    // State, counters and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= ST_FILL;
            wr_ptr  <= '0;
            step    <= '0;
            cur_s   <= '0;
            out_buf <= '0;
            o_ready <= 1'b1;
            o_valid <= 1'b0;
            o_bit   <= 1'b0;
            o_last  <= 1'b0;
        end else begin
            state   <= state_n;
            wr_ptr  <= wr_ptr_n;
            step    <= step_n;
            cur_s   <= cur_s_n;
            out_buf <= out_buf_n;
            o_ready <= ready_n;
            o_valid <= valid_n;
            o_bit   <= bit_n;
            o_last  <= last_n;
        end
    end

    // Next-state logic; outputs are computed one cycle ahead so the
    // registered o_valid/o_bit/o_last line up with the EMIT state.
    always_comb begin
        state_n   = state;
        wr_ptr_n  = wr_ptr;
        step_n    = step;
        cur_s_n   = cur_s;
        out_buf_n = out_buf;
        mem_we    = 1'b0;
        valid_n   = 1'b0;
        bit_n     = 1'b0;
        last_n    = 1'b0;

        unique case (state)
            ST_FILL: begin
                if (i_valid && o_ready) begin
                    mem_we = 1'b1;
                    if (wr_ptr == LAST) begin
                        wr_ptr_n = '0;
                        cur_s_n  = start_s;
                        step_n   = LAST;
                        state_n  = ST_TRACE;
                    end else begin
                        wr_ptr_n = wr_ptr + CNT_W'(1);
                    end
                end
            end
            ST_TRACE: begin
                // Predecessor of s is {s[0], dec[s]}; the decoded bit is s[1].
                out_buf_n[step] = cur_s[1];
                cur_s_n         = state_t'({cur_s[0], rd_dec[cur_s]});
                if (step == '0) begin
                    // buf[0] is being written this edge, so bypass it.
                    state_n = ST_EMIT;
                    valid_n = 1'b1;
                    bit_n   = cur_s[1];
                end else begin
                    step_n = step - CNT_W'(1);
                end
            end
            ST_EMIT: begin
                if (step == LAST) begin
                    step_n  = '0;
                    state_n = ST_FILL;
                end else begin
                    step_n  = step_p1;
                    valid_n = 1'b1;
                    bit_n   = out_buf[step_p1];
                    last_n  = (step_p1 == LAST);
                end
            end
            default: begin
                state_n = ST_FILL;
            end
        endcase

        ready_n = (state_n == ST_FILL);
    end

endmodule

// File: tb/tb_survivor_traceback_unit.sv
// Self-checking bench for survivor_traceback_unit (TB_DEPTH=16).
// Works with or without TRACEBACK_BEST_STATE_EN; the model follows the macro.
module tb_survivor_traceback_unit;

    localparam int D = 16;

    logic       clk;
    logic       rst_n;
    logic       i_valid;
    logic [3:0] i_dec;
    logic [1:0] i_best_state;
    logic       o_ready, o_valid, o_bit, o_last;

    int checks   = 0;
    int failures = 0;

    logic [3:0]   blk_dec [D];
    logic [1:0]   blk_best;
    logic [D-1:0] got_bits;
    int           got_cnt;

    survivor_traceback_unit #(.TB_DEPTH(D), .SIZE_STATE(2)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_valid      (i_valid),
        .i_dec        (i_dec),
        .i_best_state (i_best_state),
        .o_ready      (o_ready),
        .o_valid      (o_valid),
        .o_bit        (o_bit),
        .o_last       (o_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: walk the trellis backwards over the stored words.
    function automatic logic [D-1:0] model_bits();
        logic [D-1:0] bits;
        logic [1:0]   s;
        logic [3:0]   w;
`ifdef TRACEBACK_BEST_STATE_EN
        s = blk_best;
`else
        s = 2'd0;
`endif
        bits = '0;
        for (int k = D - 1; k >= 0; k--) begin
            bits[k] = s[1];
            w = blk_dec[k];
            s = {s[0], w[s]};
        end
        return bits;
    endfunction

    task automatic fill_block(input logic [3:0] pat, input logic [1:0] best, input bit rnd);
        for (int i = 0; i < D; i++) blk_dec[i] = rnd ? 4'($urandom_range(0, 15)) : pat;
        blk_best = rnd ? 2'($urandom_range(0, 3)) : best;
    endtask

    // Drive one block; gap inserts an idle cycle between words.
    task automatic drive_block(input bit gap);
        for (int i = 0; i < D; i++) begin
            if (gap && i > 0) begin
                @(negedge clk);
                i_valid = 1'b0;
                i_dec   = 4'($urandom_range(0, 15));
            end
            @(negedge clk);
            checks++;
            if (o_ready !== 1'b1) begin
                failures++;
                $display("FAIL fill_ready word %0d: o_ready=%b required 1", i, o_ready);
            end
            i_valid      = 1'b1;
            i_dec        = blk_dec[i];
            i_best_state = (i == D - 1) ? blk_best : 2'($urandom_range(0, 3));
        end
    endtask

    // Collect the output stream after the last word; hold keeps junk on i_valid.
    // Stops early (abort_at>0) once that many bits have been seen.
    task automatic collect(input string name, input bit hold, input int abort_at);
        logic [D-1:0] exp;
        int first_cyc;
        exp       = model_bits();
        got_bits  = '0;
        got_cnt   = 0;
        first_cyc = -1;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            if (o_valid === 1'b1) begin
                if (first_cyc < 0) begin
                    first_cyc = cyc;
                    checks++;
                    if (cyc != D + 1) begin
                        failures++;
                        $display("FAIL %s latency: first o_valid at %0d cycles required %0d", name, cyc, D + 1);
                    end
                end
                if (got_cnt < D) begin
                    got_bits[got_cnt] = o_bit;
                    checks++;
                    if (o_bit !== exp[got_cnt] || o_last !== (got_cnt == D - 1)) begin
                        failures++;
                        $display("FAIL %s bit %0d: o_bit=%b o_last=%b required %b %b",
                                 name, got_cnt, o_bit, o_last, exp[got_cnt], (got_cnt == D - 1));
                    end
                end
                got_cnt++;
                if (abort_at > 0 && got_cnt == abort_at) return;
            end else if (first_cyc < 0 && o_ready === 1'b1 && cyc > 1) begin
                checks++;
                failures++;
                $display("FAIL %s busy_ready: o_ready=1 at cycle %0d before emit", name, cyc);
            end
            if (hold) begin
                i_valid = 1'b1;
                i_dec   = 4'($urandom_range(0, 15));
            end else begin
                i_valid = 1'b0;
            end
            if (first_cyc > 0 && cyc == first_cyc + D) begin
                i_valid = 1'b0;
                checks++;
                if (o_ready !== 1'b1 || o_valid !== 1'b0 || got_cnt != D) begin
                    failures++;
                    $display("FAIL %s block_end: o_ready=%b o_valid=%b bits=%0d required 1 0 %0d",
                             name, o_ready, o_valid, got_cnt, D);
                end
                checks++;
                if (got_bits !== exp) begin
                    failures++;
                    $display("FAIL %s word: got %h required %h", name, got_bits, exp);
                end
                return;
            end
        end
        checks++;
        failures++;
        $display("FAIL %s timeout: %0d bits seen required %0d", name, got_cnt, D);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_valid = 1'b0; i_dec = '0; i_best_state = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_last !== 1'b0 || o_bit !== 1'b0) begin
            failures++;
            $display("FAIL reset: ready/valid/last/bit=%b%b%b%b required 1000", o_ready, o_valid, o_last, o_bit);
        end
    endtask

    task automatic test_patterns();
        fill_block(4'b1000, 2'd3, 1'b0);
        drive_block(1'b0);
        collect("pattern_1000", 1'b0, 0);
        fill_block(4'b0100, 2'd1, 1'b0);
        drive_block(1'b0);
        collect("pattern_0100", 1'b0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 4; n++) begin
            fill_block(4'd0, 2'd0, 1'b1);
            drive_block(1'b0);
            collect("random", 1'b0, 0);
        end
    endtask

    task automatic test_valid_held();
        fill_block(4'd0, 2'd0, 1'b1);
        drive_block(1'b0);
        collect("held_first", 1'b1, 0);
        fill_block(4'd0, 2'd0, 1'b1);
        drive_block(1'b0);
        collect("held_next", 1'b0, 0);
    endtask

    task automatic test_gapped();
        fill_block(4'd0, 2'd0, 1'b1);
        drive_block(1'b1);
        collect("gapped", 1'b0, 0);
    endtask

    task automatic test_reset_in_emit();
        fill_block(4'd0, 2'd0, 1'b1);
        drive_block(1'b0);
        collect("pre_abort", 1'b0, 5);
        rst_n = 1'b0;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_last !== 1'b0) begin
            failures++;
            $display("FAIL abort_reset: o_valid=%b o_ready=%b o_last=%b required 0 1 0", o_valid, o_ready, o_last);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 2 * D + 4; c++) begin
            @(negedge clk);
            checks++;
            if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
                failures++;
                $display("FAIL abort_idle cycle %0d: o_valid=%b o_ready=%b required 0 1", c, o_valid, o_ready);
            end
        end
        fill_block(4'd0, 2'd0, 1'b1);
        drive_block(1'b0);
        collect("post_abort", 1'b0, 0);
    endtask

    initial begin
        test_reset();
        test_patterns();
        test_random();
        test_valid_held();
        test_gapped();
        test_reset_in_emit();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
